// File: rtl/shift_arb_seq_pkg.sv
// Shared encodings for the two-requester shift-register sequencer.
// Also holds the one-step update rule used by the register datapath.
package shift_arb_seq_pkg;

    typedef enum logic [2:0] {
        OP_CLR  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_ASR  = 3'b100,
        OP_SIN  = 3'b101,
        OP_ROR  = 3'b110,
        OP_ROL  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    function automatic logic [7:0] step_q(input logic [2:0] op, input logic [7:0] q,
                                          input logic [7:0] data, input logic sdin);
        logic [7:0] r;
        case (op_e'(op))
            OP_CLR:  r = 8'h00;
            OP_LOAD: r = data;
            OP_SHR:  r = {1'b0, q[7:1]};
            OP_SHL:  r = {q[6:0], 1'b0};
            OP_ASR:  r = {q[7], q[7:1]};
            OP_SIN:  r = {sdin, q[7:1]};
            OP_ROR:  r = {q[0], q[7:1]};
            default: r = {q[6:0], q[7]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_core.sv
// Eight-bit shift register: applies one operation step on each enabled edge.
module shift_core
    import shift_arb_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] op,
    input  logic [7:0] data,
    input  logic       sdin,
    output logic [7:0] q
);

    logic [7:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 8'h00;
        end else if (en) begin
            q_q <= step_q(op, q_q, data, sdin);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_arb_seq.sv
// Round-robin arbiter between two command channels driving a multi-step
// shift register; reports each finished command once on the rsp channel.
module shift_arb_seq
    import shift_arb_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [2:0] a_op,
    input  logic [2:0] a_cnt,
    input  logic [7:0] a_data,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [2:0] b_op,
    input  logic [2:0] b_cnt,
    input  logic [7:0] b_data,
    input  logic       sdin,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [7:0] q
);

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] steps_q, steps_d;
    logic [7:0] data_q, data_d;
    logic       id_q, id_d;
    logic       rr_last_q, rr_last_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_id_q, rsp_id_d;
    logic       grant_b;
    logic       accept;
    logic [2:0] sel_op;
    logic [7:0] q_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'd0;
            steps_q    <= 3'd0;
            data_q     <= 8'h00;
            id_q       <= 1'b0;
            rr_last_q  <= 1'b1;
            rsp_data_q <= 8'h00;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            steps_q    <= steps_d;
            data_q     <= data_d;
            id_q       <= id_d;
            rr_last_q  <= rr_last_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        steps_d    = steps_q;
        data_d     = data_q;
        id_d       = id_q;
        rr_last_d  = rr_last_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;

        // With no contender the grant parks on whoever would win a tie.
        if (a_valid && b_valid) grant_b = !rr_last_q;
        else if (a_valid)       grant_b = 1'b0;
        else if (b_valid)       grant_b = 1'b1;
        else                    grant_b = !rr_last_q;

        a_ready = (state_q == ST_IDLE) && !grant_b;
        b_ready = (state_q == ST_IDLE) && grant_b;
        accept  = grant_b ? (b_valid && b_ready) : (a_valid && a_ready);
        sel_op  = grant_b ? b_op : a_op;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_EXEC;
                    op_d      = sel_op;
                    data_d    = grant_b ? b_data : a_data;
                    // steps_q holds remaining steps minus one; clear/load are single-step
                    steps_d   = (sel_op[2:1] == 2'b00) ? 3'd0 : (grant_b ? b_cnt : a_cnt);
                    id_d      = grant_b;
                    rr_last_d = grant_b;
                end
            end
            ST_EXEC: begin
                if (steps_q == 3'd0) state_d = ST_RESP;
                else                 steps_d = steps_q - 3'd1;
            end
            ST_RESP: begin
                state_d    = ST_IDLE;
                rsp_data_d = q_w;
                rsp_id_d   = id_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    shift_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_EXEC),
        .op    (op_q),
        .data  (data_q),
        .sdin  (sdin),
        .q     (q_w)
    );

    // During RESP the fresh result is shown directly, then held in the _q copies.
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_valid ? q_w : rsp_data_q;
    assign rsp_id    = rsp_valid ? id_q : rsp_id_q;
    assign busy      = (state_q != ST_IDLE);
    assign q         = q_w;

endmodule

// File: tb/tb_shift_arb_seq.sv
// Self-checking bench: directed scenarios plus random traffic, checked each
// cycle against a job-level behavioural model of the sequencer.
module tb_shift_arb_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, a_ready, b_ready;
    logic [2:0] a_op, a_cnt, b_op, b_cnt;
    logic [7:0] a_data, b_data;
    logic       sdin;
    logic       rsp_valid, rsp_id, busy;
    logic [7:0] rsp_data, q;

    int n_vec = 0;
    int n_err = 0;

    shift_arb_seq dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_cnt(a_cnt), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_cnt(b_cnt), .b_data(b_data),
        .sdin(sdin), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .q(q)
    );

    always #5 clk = ~clk;

    // Model: a job is in flight for 'left' more register steps, then one report cycle.
    int       m_phase;   // 0 waiting for a command, 1 stepping, 2 reporting
    int       m_left;
    logic [2:0] m_op;
    logic [7:0] m_data, m_q, m_rsp_data;
    logic     m_id, m_rsp_id, m_last;
    logic     m_acc, m_acc_id;

    function automatic logic [7:0] m_step(input logic [2:0] op, input logic [7:0] v,
                                          input logic [7:0] d, input logic s);
        int x;
        x = v;
        case (op)
            3'd0: x = 0;
            3'd1: x = d;
            3'd2: x = x / 2;
            3'd3: x = (x * 2) % 256;
            3'd4: x = x / 2 + (x >= 128 ? 128 : 0);
            3'd5: x = x / 2 + (s ? 128 : 0);
            3'd6: x = x / 2 + ((x % 2) * 128);
            default: x = (x * 2) % 256 + (x >= 128 ? 1 : 0);
        endcase
        return x[7:0];
    endfunction

    function automatic logic m_winner();
        if (a_valid && b_valid) return !m_last;
        if (a_valid) return 1'b0;
        if (b_valid) return 1'b1;
        return !m_last;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_q = 8'h00; m_rsp_data = 8'h00;
        m_rsp_id = 1'b0; m_last = 1'b1; m_acc = 1'b0;
    endtask

    task automatic model_edge();
        logic w;
        m_acc = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_phase == 0) begin
            w = m_winner();
            if (w ? b_valid : a_valid) begin
                m_op   = w ? b_op : a_op;
                m_data = w ? b_data : a_data;
                m_left = (m_op < 2) ? 1 : int'(w ? b_cnt : a_cnt) + 1;
                m_id   = w; m_last = w; m_phase = 1;
                m_acc  = 1'b1; m_acc_id = w;
            end
        end else if (m_phase == 1) begin
            m_q = m_step(m_op, m_q, m_data, sdin);
            m_left--;
            if (m_left == 0) begin
                m_phase = 2; m_rsp_data = m_q; m_rsp_id = m_id;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic w;
        w = m_winner();
        chk("q", q, m_q);
        chk("busy", {7'd0, busy}, {7'd0, m_phase != 0});
        chk("rsp_valid", {7'd0, rsp_valid}, {7'd0, m_phase == 2});
        chk("rsp_data", rsp_data, m_rsp_data);
        chk("rsp_id", {7'd0, rsp_id}, {7'd0, m_rsp_id});
        chk("a_ready", {7'd0, a_ready}, {7'd0, m_phase == 0 && !w});
        chk("b_ready", {7'd0, b_ready}, {7'd0, m_phase == 0 && w});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    // Issue one command; report steps-to-response, response and busy-cycle count.
    task automatic do_cmd(input logic id, input logic [2:0] op, input logic [2:0] cnt,
                          input logic [7:0] data, input logic sd,
                          output int lat, output logic [7:0] rd, output logic rid,
                          output int nbusy);
        int k;
        sdin = sd;
        if (id) begin b_valid = 1; b_op = op; b_cnt = cnt; b_data = data; end
        else    begin a_valid = 1; a_op = op; a_cnt = cnt; a_data = data; end
        k = 0;
        do begin tick(); k++; end while (!m_acc && k < 10);
        if (!m_acc) begin n_err++; $display("FAIL accept_timeout: no accept in 10 cycles"); end
        a_valid = 0; b_valid = 0;
        lat = 0; nbusy = busy ? 1 : 0; rd = 8'hxx; rid = 1'bx;
        for (int i = 0; i < 14 && busy; i++) begin
            tick();
            if (busy) nbusy++;
            if (lat == 0 && rsp_valid) begin lat = i + 1; rd = rsp_data; rid = rsp_id; end
        end
        $display("cmd id=%0d op=%0d cnt=%0d data=%02h -> rsp %02h id=%0d lat=%0d busy=%0d",
                 id, op, cnt, data, rd, rid, lat, nbusy);
    endtask

    int lat, nb;
    logic [7:0] rd;
    logic rid;
    logic [1:0] order [$];

    initial begin
        rst_n = 0; a_valid = 1; b_valid = 0; sdin = 0;
        a_op = 3'd1; a_cnt = 0; a_data = 8'h55; b_op = 0; b_cnt = 0; b_data = 0;
        model_reset();
        @(negedge clk); tick();
        chk("reset_q", q, 8'h00);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_a_ready", {7'd0, a_ready}, 8'd1);
        a_valid = 0;
        rst_n = 1;
        tick();

        do_cmd(0, 3'd1, 3'd5, 8'hA5, 0, lat, rd, rid, nb);
        chk("load_rsp", rd, 8'hA5); chk("load_id", {7'd0, rid}, 8'd0);
        chk("load_lat", lat[7:0], 8'd1);

        do_cmd(0, 3'd1, 3'd0, 8'h81, 0, lat, rd, rid, nb);
        do_cmd(0, 3'd4, 3'd2, 8'h00, 0, lat, rd, rid, nb);
        chk("asr_rsp", rd, 8'hF0); chk("asr_lat", lat[7:0], 8'd3);

        do_cmd(1, 3'd1, 3'd0, 8'h01, 0, lat, rd, rid, nb);
        chk("b_id", {7'd0, rid}, 8'd1);
        do_cmd(0, 3'd5, 3'd3, 8'h00, 1, lat, rd, rid, nb);
        chk("sin_rsp", rd, 8'hF0); chk("sin_busy", nb[7:0], 8'd5);

        do_cmd(0, 3'd1, 3'd0, 8'h3C, 0, lat, rd, rid, nb);
        do_cmd(1, 3'd7, 3'd7, 8'h00, 0, lat, rd, rid, nb);
        chk("rol8_rsp", rd, 8'h3C); chk("rol8_lat", lat[7:0], 8'd8);

        // Reset mid-command, then tie tests from the fresh reset pointer.
        a_valid = 1; a_op = 3'd2; a_cnt = 3'd7; a_data = 0;
        tick(); a_valid = 0; tick(); tick();
        rst_n = 0; model_reset(); #1;
        chk("abort_q", q, 8'h00); chk("abort_busy", {7'd0, busy}, 8'd0);
        tick(); rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_rsp", {7'd0, rsp_valid}, 8'd0);
        end
        chk("abort_q_after", q, 8'h00);

        a_valid = 1; b_valid = 1; a_op = 1; b_op = 1; a_data = 8'h11; b_data = 8'h22;
        for (int i = 0; i < 30 && order.size() < 3; i++) begin
            tick();
            if (m_acc) begin
                order.push_back({1'b0, m_acc_id});
                if (order.size() == 2) begin a_valid = 1; b_valid = 1; end
                else if (m_acc_id) b_valid = 0; else a_valid = 0;
                $display("tie accept %0d id=%0d", order.size(), m_acc_id);
            end
        end
        a_valid = 0; b_valid = 0;
        if (order.size() != 3) begin
            n_err++; $display("FAIL tie_timeout: got %0d accepts expected 3", order.size());
        end else begin
            chk("tie_first", {6'd0, order[0]}, 8'd0);
            chk("tie_second", {6'd0, order[1]}, 8'd1);
            chk("tie_third", {6'd0, order[2]}, 8'd0);
        end
        for (int i = 0; i < 4; i++) tick();

        for (int i = 0; i < 1500; i++) begin
            a_valid = ($urandom_range(0, 2) != 0); b_valid = ($urandom_range(0, 2) != 0);
            a_op = 3'($urandom); a_cnt = 3'($urandom); a_data = 8'($urandom);
            b_op = 3'($urandom); b_cnt = 3'($urandom); b_data = 8'($urandom);
            sdin = 1'($urandom);
            if ($urandom_range(0, 150) == 0) begin rst_n = 0; model_reset(); end
            else rst_n = 1;
            tick();
        end
        rst_n = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_arb_seq.md
SHIFT_ARB_SEQ -- requirements
Module: shift_arb_seq

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: a_valid in 1, a_ready out 1, a_op in 3, a_cnt in 3, a_data in 8  requester A command channel.
REQ-004 SHALL have ports: b_valid in 1, b_ready out 1, b_op in 3, b_cnt in 3, b_data in 8  requester B command channel.
REQ-005 SHALL have port: sdin  in  1  serial bit consumed by serial-in op, sampled every step.
REQ-006 SHALL have ports: rsp_valid out 1, rsp_id out 1 (0=A, 1=B), rsp_data out 8  completion report, no backpressure.
REQ-007 SHALL have ports: busy out 1 (state != IDLE), q out 8 (live shift register value).

Function
REQ-008 SHALL implement FSM states IDLE, EXEC, RESP; IDLE->EXEC on accept, EXEC->RESP after last step, RESP->IDLE unconditionally.
REQ-009 SHALL assert x_ready only in IDLE and only for the granted requester; accept = x_valid && x_ready on a rising edge.
REQ-010 SHALL arbitrate in IDLE: single valid requester wins; both valid -> requester not served last wins (round-robin); pointer updates only on accept.
REQ-011 SHALL latch op, cnt, data and id at accept; later changes on the command ports have no effect until next accept.
REQ-012 SHALL encode op: 000 clear Q=0; 001 load Q=data; 010 Q={0,Q[7:1]}; 011 Q={Q[6:0],0}; 100 Q={Q[7],Q[7:1]}; 101 Q={sdin,Q[7:1]}; 110 Q={Q[0],Q[7:1]}; 111 Q={Q[6:0],Q[7]}.
REQ-013 SHALL perform exactly one step per EXEC cycle; ops 000/001 take 1 step regardless of cnt; ops 010-111 take cnt+1 steps (1..8).
REQ-014 SHALL hold Q in IDLE and RESP; Q changes only on EXEC step edges.
REQ-015 SHALL assert rsp_valid for exactly one cycle (RESP) with rsp_data = Q after final step and rsp_id = latched id.
REQ-016 SHALL give latency: accept at edge T, steps at edges T+1..T+n, rsp_valid high in cycle after edge T+n, earliest next accept at edge T+n+2.
REQ-017 SHALL hold rsp_data and rsp_id stable after RESP until the next RESP.
REQ-018 SHALL, for cnt=7 rotate ops, return Q to original value after 8 steps (wrap-around exact).

Reset
REQ-019 SHALL on rst_n low immediately force: state IDLE, Q=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, a_ready/b_ready from IDLE arbitration, round-robin pointer = "B served last" (A wins first tie).
REQ-020 SHALL abort an in-flight command on reset with no response; first command after release starts from Q=0.
REQ-021 SHALL accept no command on the first rising edge where rst_n is low; acceptance begins on the first edge after rst_n deasserts.

Structure
REQ-022 SHALL place op encodings and FSM state encoding in shared package shift_arb_seq_pkg.
REQ-023 SHALL isolate the register datapath in sub-module shift_core (ports: clk, rst_n, en, op[2:0], data[7:0], sdin, q[7:0]); the FSM, counter and arbiter stay in shift_arb_seq.

Verification
REQ-024 SHALL cover: A load data=8'hA5 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=8'hA5.
REQ-025 SHALL cover: after load 8'h81, A op 100 cnt=2 -> 3 steps, rsp_data=8'hF0.
REQ-026 SHALL cover: A and B valid simultaneously from reset, both loading -> A granted first, then B; next tie grants A again.
REQ-027 SHALL cover: load 8'h01, op 101 cnt=3 with sdin=1 every step -> rsp_data=8'hF0, busy high for 4 EXEC cycles + 1 RESP.
REQ-028 SHALL cover: load 8'h3C, op 111 cnt=7 -> rsp_data=8'h3C; then rst_n pulsed mid op 010 -> no rsp_valid, q=8'h00.
